window_3x3_former: RTL

//   Sits directly downstream of two cascaded Line_buffer_datapath instances in the preparation module.

---
 rtl/window_3x3_former.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/window_3x3_former.sv
// 3x3 neighbourhood former that drives two cascaded line buffers from a raster pixel stream.
// Optional macro WINDOW_COORD_EN adds centre-pixel coordinate outputs x_o / y_o.
module window_3x3_former #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 1024,
    parameter int IMG_HEIGHT = 768
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_i,
    input  logic [DATA_WIDTH-1:0]             pixel_i,
    input  logic [DATA_WIDTH-1:0]             lb0_data_i,
    input  logic [DATA_WIDTH-1:0]             lb1_data_i,
    output logic                              lb0_wr_en_o,
    output logic                              lb0_rd_en_o,
    output logic                              lb1_wr_en_o,
    output logic                              lb1_rd_en_o,
    output logic [9*DATA_WIDTH-1:0]           window_o,
    output logic                              valid_o,
    output logic                              done_o,
    output logic                              busy_o
`ifdef WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]      x_o,
    output logic [$clog2(IMG_HEIGHT)-1:0]     y_o
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   win_q [9];
    logic [DATA_WIDTH-1:0]   win_d [9];
    logic [DATA_WIDTH-1:0]   new_col [3];

    logic row_ge1, row_ge2, last_col, last_row, win_ok;

    assign row_ge1  = (row_q >= ROW_ONE);
    assign row_ge2  = (row_q >= ROW_TWO);
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign win_ok   = row_ge2 && (col_q >= COL_TWO);

    assign lb0_wr_en_o = valid_i;
    assign lb0_rd_en_o = valid_i && row_ge1;
    assign lb1_wr_en_o = valid_i && row_ge1;
    assign lb1_rd_en_o = valid_i && row_ge2;

    // Line buffers are undriven until they hold a full line, so gate them to zero.
    assign new_col[0] = row_ge2 ? lb1_data_i : '0;
    assign new_col[1] = row_ge1 ? lb0_data_i : '0;
    assign new_col[2] = pixel_i;

    assign valid_o = valid_q;
    assign done_o  = (state_q == DONE);
    assign busy_o  = (state_q != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pack
            assign window_o[(8-gi)*DATA_WIDTH +: DATA_WIDTH] = win_q[gi];
        end
    endgenerate

`ifdef WINDOW_COORD_EN
    logic [CW-1:0] x_q, x_d;
    logic [RW-1:0] y_q, y_d;
    assign x_o = x_q;
    assign y_o = y_q;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        win_d   = win_q;
`ifdef WINDOW_COORD_EN
        x_d     = x_q;
        y_d     = y_q;
`endif
        if (valid_i) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
                win_d[r*3+2] = new_col[r];
            end
            valid_d = win_ok;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_ONE;
            end else begin
                col_d = col_q + COL_ONE;
            end
`ifdef WINDOW_COORD_EN
            if (win_ok) begin
                x_d = col_q - COL_ONE;
                y_d = row_q - ROW_ONE;
            end
`endif
        end

        case (state_q)
            IDLE:    if (valid_i) state_d = FILL;
            FILL:    if (valid_i && row_q == ROW_ONE && last_col) state_d = RUN;
            RUN:     if (valid_i && last_row && last_col) state_d = DONE;
            DONE:    state_d = valid_i ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
`ifdef WINDOW_COORD_EN
            x_q     <= '0;
            y_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            win_q   <= win_d;
`ifdef WINDOW_COORD_EN
            x_q     <= x_d;
            y_q     <= y_d;
`endif
        end
    end

endmodule
